// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (length, data, XOR checksum)
// and writes little-endian packed 32-bit words into the imem write port.
module imem_loader #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Stream handshake: a byte moves only in a cycle where in_valid and in_ready
    // are both high; in_ready depends on state alone, never on in_valid.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    logic [2:0]        state_q,    state_d;
    logic [7:0]        len_lo_q,   len_lo_d;
    logic [15:0]       len_q,      len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [23:0]       word_q,     word_d;
    logic [7:0]        csum_q,     csum_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_a_q,    mem_a_d;
    logic [31:0]       mem_d_q,    mem_d_d;
    logic              err_q,      err_d;

    logic        xfer;
    logic        active;
    logic [15:0] len_rx;

    assign active = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer   = in_valid && active;
    assign len_rx = {in_data, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        mem_we_d   = 1'b0;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN0;
                    err_d      = 1'b0;
                    csum_d     = 8'h00;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 16'd0;
                    word_d     = 24'h0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d = len_rx;
                    if ({1'b0, len_rx} > MAX_LEN) begin
                        // Oversized frame: reject before any word is written.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d   = 1'b1;
                        mem_d_d    = {in_data, word_q};
                        mem_a_d    = BASE_ADDR + word_idx_q[ADDR_W-1:0];
                        byte_cnt_d = 2'd0;
                        if (word_idx_q == len_q - 16'd1) begin
                            state_d = S_CSUM;
                        end else begin
                            word_idx_d = word_idx_q + 16'd1;
                        end
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    word_d[7:0]   = in_data;
                            2'd1:    word_d[15:8]  = in_data;
                            default: word_d[23:16] = in_data;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    err_d   = (in_data != csum_q);
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_lo_q   <= 8'h00;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 16'd0;
            word_q     <= 24'h0;
            csum_q     <= 8'h00;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_d_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = active;
    assign busy      = active;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_a     = mem_a_q;
    assign mem_d     = mem_d_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0xFFF) share one stream;
// a frame-level model predicts each word write and when it must appear.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        in_ready0, mem_we0, busy0, done0, err0;
    logic [11:0] mem_a0;
    logic [31:0] mem_d0;
    logic [2:0]  dbg0;
    logic        in_ready1, mem_we1, busy1, done1, err1;
    logic [11:0] mem_a1;
    logic [31:0] mem_d1;
    logic [2:0]  dbg1;

    imem_loader #(.ADDR_W(12), .BASE_ADDR(12'h000)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_a(mem_a0), .mem_d(mem_d0),
        .busy(busy0), .done(done0), .err(err0), .dbg_state(dbg0)
    );

    imem_loader #(.ADDR_W(12), .BASE_ADDR(12'hFFF)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_a(mem_a1), .mem_d(mem_d1),
        .busy(busy1), .done(done1), .err(err1), .dbg_state(dbg1)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;
    int xfer_cyc = 0;

    // scoreboard: {due cycle[31:0], word index[11:0], data[31:0]}
    logic [75:0] exp_q[$];
    logic [43:0] log0[$];
    logic [43:0] log1[$];
    logic [7:0]  fb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare process
    always @(negedge clk) begin
        logic        exp_we;
        logic [11:0] idx;
        logic [11:0] a1;
        #1;
        exp_we = (exp_q.size() > 0) && (exp_q[0][75:44] == cyc);
        chk("mem_we0", {63'd0, mem_we0}, {63'd0, exp_we});
        chk("mem_we1", {63'd0, mem_we1}, {63'd0, exp_we});
        if (exp_we) begin
            idx = exp_q[0][43:32];
            a1  = 12'hFFF + idx;
            chk("mem_a0", {52'd0, mem_a0}, {52'd0, idx});
            chk("mem_a1", {52'd0, mem_a1}, {52'd0, a1});
            chk("mem_d0", {32'd0, mem_d0}, {32'd0, exp_q[0][31:0]});
            chk("mem_d1", {32'd0, mem_d1}, {32'd0, exp_q[0][31:0]});
            void'(exp_q.pop_front());
        end
        if (mem_we0) log0.push_back({mem_a0, mem_d0});
        if (mem_we1) log1.push_back({mem_a1, mem_d1});
        chk("ready_eq_busy0", {63'd0, in_ready0}, {63'd0, busy0});
        chk("ready_eq_busy1", {63'd0, in_ready1}, {63'd0, busy1});
        chk("busy_done_excl", {63'd0, busy0 & done0}, 64'd0);
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready0) begin
            n_vec++;
            n_mis++;
            $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready0);
            in_valid = 1'b0;
            return;
        end
        xfer_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_busy", {63'd0, busy0}, 64'd1);
        chk("start_done", {63'd0, done0}, 64'd0);
        chk("start_err", {63'd0, err0}, 64'd0);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {62'd0, in_ready0, in_ready1}, 64'd0);
        chk("rst_mem_we", {62'd0, mem_we0, mem_we1}, 64'd0);
        chk("rst_mem_a", {40'd0, mem_a0, mem_a1}, 64'd0);
        chk("rst_mem_d0", {32'd0, mem_d0}, 64'd0);
        chk("rst_mem_d1", {32'd0, mem_d1}, 64'd0);
        chk("rst_flags", {58'd0, busy0, busy1, done0, done1, err0, err1}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Sends one frame from fb; word writes are predicted from the byte list.
    task automatic run_frame(input logic [15:0] len, input logic [7:0] csum,
                             input int gap_mod, input logic poke_start, input logic exp_err);
        logic [31:0] w;
        int gap;
        do_start();
        send_byte(len[7:0], 0);
        if (poke_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        send_byte(len[15:8], 0);
        if (len > 16'd4096) begin
            #1;
            chk("biglen_done", {63'd0, done0}, 64'd1);
            chk("biglen_err", {63'd0, err0}, 64'd1);
            chk("biglen_busy", {63'd0, busy0}, 64'd0);
            repeat (3) @(negedge clk);
            return;
        end
        for (int i = 0; i < fb.size(); i++) begin
            gap = (gap_mod > 0) ? (i % gap_mod) : 0;
            send_byte(fb[i], gap);
            if (i % 4 == 3) begin
                w = {fb[i], fb[i-1], fb[i-2], fb[i-3]};
                exp_q.push_back({xfer_cyc[31:0], 12'(i / 4), w});
            end
        end
        send_byte(csum, gap_mod);
        #1;
        chk("frame_done0", {63'd0, done0}, 64'd1);
        chk("frame_done1", {63'd0, done1}, 64'd1);
        chk("frame_err0", {63'd0, err0}, {63'd0, exp_err});
        chk("frame_err1", {63'd0, err1}, {63'd0, exp_err});
        chk("frame_busy", {63'd0, busy0}, 64'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("done_held", {63'd0, done0}, 64'd1);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", {63'd0, busy0}, 64'd0);
        chk("reset_done", {63'd0, done0}, 64'd0);
        chk("reset_mem_a1", {52'd0, mem_a1}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // two words, correct checksum (XOR of all eight data bytes = 0x2A)
        fb = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame(16'd2, 8'h2A, 0, 1'b0, 1'b0);
        chk("log0_n", 64'(log0.size()), 64'd2);
        chk("log0_w0", {20'd0, log0[0]}, {20'd0, 12'h000, 32'h12345678});
        chk("log0_w1", {20'd0, log0[1]}, {20'd0, 12'h001, 32'hDEADBEEF});
        chk("log1_w0", {20'd0, log1[0]}, {20'd0, 12'hFFF, 32'h12345678});
        chk("log1_w1", {20'd0, log1[1]}, {20'd0, 12'h000, 32'hDEADBEEF});
        chk("hold_a0", {52'd0, mem_a0}, 64'h001);
        chk("hold_d0", {32'd0, mem_d0}, 64'hDEADBEEF);

        // same frame, bad checksum, with input gaps; restart from DONE
        run_frame(16'd2, 8'h2B, 3, 1'b0, 1'b1);
        chk("log0_n2", 64'(log0.size()), 64'd4);

        // zero-length frames
        fb = {};
        run_frame(16'd0, 8'h00, 0, 1'b0, 1'b0);
        run_frame(16'd0, 8'h01, 0, 1'b0, 1'b1);

        // oversize length 0x1001
        run_frame(16'h1001, 8'h00, 0, 1'b0, 1'b1);
        chk("no_write_len", 64'(log0.size()), 64'd4);

        // length 0x1000 is the largest accepted
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        #1;
        chk("len4096_busy", {63'd0, busy0}, 64'd1);
        chk("len4096_done", {63'd0, done0}, 64'd0);
        do_rst();

        // partial word with random gaps, then reset
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, $urandom_range(0, 3));
        send_byte(8'hBB, $urandom_range(0, 3));
        do_rst();
        repeat (3) @(negedge clk);
        chk("no_write_rst", 64'(log0.size()), 64'd4);

        // fresh frame loads; a start pulse mid-frame is ignored
        fb = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(16'd1, 8'h44, 2, 1'b1, 1'b0);
        chk("final_w0", {20'd0, log0[log0.size()-1]}, {20'd0, 12'h000, 32'h44332211});
        chk("final_w1", {20'd0, log1[log1.size()-1]}, {20'd0, 12'hFFF, 32'h44332211});

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
